fc_layer: RTL and testbench

- Two-stage fully connected inference block, the final dense section of the LBCNN datapath.
- Stage 1: IP_LAYER hidden neurons. Each neuron takes the dot product of NUM_INP inputs with NUM_INP weights, then applies ReLU.
- Stage 2: a single output neuron forms the weighted sum of the hidden values with dense_wt, adds bias, and produces one signed 16-bit score.
- Runs continuously. Operands are snapshotted at the start of every pass, and each finished result is flagged by out_valid.

---
 rtl/fc_layer.sv | 116 +++++++++++
 tb/tb_fc_layer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer.sv
// Two-stage dense layer: IP_LAYER ReLU hidden neurons feeding one biased output neuron.
// A pass is LOAD (snapshot), IP_LAYER COMPUTE cycles (one hidden neuron each), then OUTPUT.
module fc_layer #(
  parameter int IP_LAYER = 8,
  parameter int NUM_INP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] inputs   [IP_LAYER*NUM_INP],
  input  logic signed [15:0] weights  [IP_LAYER*NUM_INP],
  input  logic signed [15:0] dense_wt [IP_LAYER],
  input  logic signed [15:0] bias,
  output logic signed [15:0] ot,
  output logic               out_valid
);

  localparam int NW = (IP_LAYER > 1) ? $clog2(IP_LAYER) : 1;
  localparam int SW = 32 + ((NUM_INP > 1) ? $clog2(NUM_INP) : 1);
  localparam int AW = 48;

  localparam logic [NW-1:0]        N_LAST = NW'(IP_LAYER - 1);
  localparam logic [NW-1:0]        N_ONE  = NW'(1);
  localparam logic signed [SW-1:0] H_MAX  = SW'(32767);
  localparam logic signed [AW-1:0] O_MAX  = AW'(32767);
  localparam logic signed [AW-1:0] O_MIN  = -AW'(32768);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state, state_nx;
  logic [NW-1:0] n;

  logic signed [15:0] x_q  [IP_LAYER*NUM_INP];
  logic signed [15:0] w_q  [IP_LAYER*NUM_INP];
  logic signed [15:0] dw_q [IP_LAYER];
  logic signed [15:0] bias_q;
  logic signed [AW-1:0] acc;

  logic signed [31:0]   prod [NUM_INP];
  logic signed [SW-1:0] dot;
  logic signed [15:0]   hidden;
  logic signed [31:0]   wprod;
  logic signed [AW-1:0] final_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = COMPUTE;
      COMPUTE: if (n == N_LAST) state_nx = OUTPUT;
      OUTPUT:  state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Hidden neuron n: parallel products summed at full width, then ReLU clamped to 16 bits.
  always_comb begin
    dot = '0;
    for (int k = 0; k < NUM_INP; k++) begin
      prod[k] = 32'(x_q[int'(n) * NUM_INP + k]) * 32'(w_q[int'(n) * NUM_INP + k]);
      dot     = dot + SW'(prod[k]);
    end
    if (dot[SW-1])       hidden = 16'sd0;
    else if (dot > H_MAX) hidden = 16'sd32767;
    else                 hidden = dot[15:0];
    wprod     = 32'(hidden) * 32'(dw_q[n]);
    final_sum = acc + AW'(bias_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n         <= '0;
      acc       <= '0;
      ot        <= '0;
      out_valid <= 1'b0;
      bias_q    <= '0;
      for (int i = 0; i < IP_LAYER*NUM_INP; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      for (int i = 0; i < IP_LAYER; i++) dw_q[i] <= '0;
    end else begin
      out_valid <= (state == OUTPUT);
      case (state)
        LOAD: begin
          for (int i = 0; i < IP_LAYER*NUM_INP; i++) begin
            x_q[i] <= inputs[i];
            w_q[i] <= weights[i];
          end
          for (int i = 0; i < IP_LAYER; i++) dw_q[i] <= dense_wt[i];
          bias_q <= bias;
          acc    <= '0;
          n      <= '0;
        end
        COMPUTE: begin
          acc <= acc + AW'(wprod);
          n   <= n + N_ONE;
        end
        OUTPUT: begin
          if (final_sum > O_MAX)      ot <= 16'sd32767;
          else if (final_sum < O_MIN) ot <= -16'sd32768;
          else                        ot <= final_sum[15:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: pulse timing, reset abort, ReLU, saturation, indexing, snapshot.
module tb_fc_layer;

  localparam int IP_LAYER = 8;
  localparam int NUM_INP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] inputs   [IP_LAYER*NUM_INP];
  logic signed [15:0] weights  [IP_LAYER*NUM_INP];
  logic signed [15:0] dense_wt [IP_LAYER];
  logic signed [15:0] bias;
  logic signed [15:0] ot;
  logic               out_valid;

  int total = 0;
  int bad   = 0;

  fc_layer #(.IP_LAYER(IP_LAYER), .NUM_INP(NUM_INP)) dut (
    .clk(clk), .rst(rst), .inputs(inputs), .weights(weights),
    .dense_wt(dense_wt), .bias(bias), .ot(ot), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic signed [15:0] xv, input logic signed [15:0] wv,
                               input logic signed [15:0] dv, input logic signed [15:0] bv);
    for (int i = 0; i < IP_LAYER*NUM_INP; i++) begin
      inputs[i]  = xv;
      weights[i] = wv;
    end
    for (int i = 0; i < IP_LAYER; i++) dense_wt[i] = dv;
    bias = bv;
  endtask

  // Waits (bounded) for the next out_valid, sampled on falling edges.
  task automatic wait_pulse();
    bit seen = 0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL pulse_timeout: out_valid=%b required=1", out_valid);
    end
  endtask

  // Second pulse after an operand change is guaranteed to use the new operands.
  task automatic settle(output logic signed [15:0] val);
    wait_pulse();
    wait_pulse();
    val = ot;
  endtask

  task automatic test_reset();
    int edges = 0;
    int pulses = 0;
    int at [3];
    applyStimulus(16'sd1, 16'sd1, 16'sd1, 16'sd0);
    rst = 1'b1;
    #12;
    total++;
    if (ot !== 16'sd0 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_state: ot=%0d valid=%b required ot=0 valid=0", ot, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    while (pulses < 3 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (out_valid === 1'b1) begin
        at[pulses] = edges;
        pulses++;
        @(negedge clk);
        edges++;
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("[TB] FAIL pulse_width: valid=%b required=0 at edge %0d", out_valid, edges);
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      total++;
      if (pulses <= p || at[p] != 10 * (p + 1)) begin
        bad++; $display("[TB] FAIL pulse_edge%0d: edge=%0d required=%0d", p, (pulses > p) ? at[p] : -1, 10 * (p + 1));
      end
    end
  endtask

  task automatic test_baseline();
    logic signed [15:0] v;
    applyStimulus(16'sd1, 16'sd1, 16'sd1, 16'sd0);
    settle(v);
    total++;
    if (v !== 16'sd64) begin bad++; $display("[TB] FAIL baseline: ot=%0d required=64", v); end
    bias = -16'sd14;
    settle(v);
    total++;
    if (v !== 16'sd50) begin bad++; $display("[TB] FAIL baseline_bias: ot=%0d required=50", v); end
  endtask

  task automatic test_reset_mid_compute();
    wait_pulse();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (ot !== 16'sd0 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_async: ot=%0d valid=%b required ot=0 valid=0", ot, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    begin
      int edges = 0;
      bit seen = 0;
      while (!seen && edges < 25) begin
        @(negedge clk);
        edges++;
        if (out_valid === 1'b1) seen = 1;
      end
      total++;
      if (!seen || edges != 10 || ot !== 16'sd50) begin
        bad++; $display("[TB] FAIL reset_restart: edge=%0d ot=%0d required edge=10 ot=50", edges, ot);
      end
    end
  endtask

  task automatic test_relu();
    logic signed [15:0] v;
    applyStimulus(16'sd1, -16'sd1, 16'sd1, 16'sd5);
    settle(v);
    total++;
    if (v !== 16'sd5) begin bad++; $display("[TB] FAIL relu: ot=%0d required=5", v); end
    bias = -16'sd200;
    settle(v);
    total++;
    if (v !== -16'sd200) begin bad++; $display("[TB] FAIL relu_bias: ot=%0d required=-200", v); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] v;
    applyStimulus(16'sd100, 16'sd100, 16'sd0, 16'sd0);
    dense_wt[0] = 16'sd1;
    settle(v);
    total++;
    if (v !== 16'sd32767) begin bad++; $display("[TB] FAIL sat_hidden: ot=%0d required=32767", v); end
    for (int i = 0; i < IP_LAYER; i++) dense_wt[i] = 16'sd1;
    settle(v);
    total++;
    if (v !== 16'sd32767) begin bad++; $display("[TB] FAIL sat_pos: ot=%0d required=32767", v); end
    for (int i = 0; i < IP_LAYER; i++) dense_wt[i] = -16'sd1;
    settle(v);
    total++;
    if (v !== -16'sd32768) begin bad++; $display("[TB] FAIL sat_neg: ot=%0d required=-32768", v); end
  endtask

  task automatic test_indexing();
    logic signed [15:0] v;
    applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    inputs[26]  = 16'sd2;
    weights[26] = 16'sd3;
    dense_wt[3] = 16'sd4;
    settle(v);
    total++;
    if (v !== 16'sd24) begin bad++; $display("[TB] FAIL index_hit: ot=%0d required=24", v); end
    dense_wt[3] = 16'sd0;
    dense_wt[2] = 16'sd4;
    settle(v);
    total++;
    if (v !== 16'sd0) begin bad++; $display("[TB] FAIL index_miss: ot=%0d required=0", v); end
  endtask

  task automatic test_snapshot();
    logic signed [15:0] v;
    dense_wt[2] = 16'sd0;
    dense_wt[3] = 16'sd4;
    settle(v);
    total++;
    if (v !== 16'sd24) begin bad++; $display("[TB] FAIL snap_setup: ot=%0d required=24", v); end
    wait_pulse();
    @(negedge clk);
    inputs[26] = 16'sd5;
    wait_pulse();
    total++;
    if (ot !== 16'sd24) begin bad++; $display("[TB] FAIL snap_old: ot=%0d required=24", ot); end
    wait_pulse();
    total++;
    if (ot !== 16'sd60) begin bad++; $display("[TB] FAIL snap_new: ot=%0d required=60", ot); end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_reset_mid_compute();
    test_relu();
    test_saturation();
    test_indexing();
    test_snapshot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
